// File: rtl/screen_phase_ctrl_pkg.sv
// Shared phase encodings and overlay masks for the screen-phase sequencer.
// The compositor decodes the same MASK_* values.
package screen_phase_ctrl_pkg;

  localparam logic [1:0] MASK_SELECT = 2'b01;
  localparam logic [1:0] MASK_GAME   = 2'b00;
  localparam logic [1:0] MASK_RESULT = 2'b10;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_GAME      = 2'd2,
    ST_RESULT    = 2'd3
  } phase_t;

  function automatic logic [1:0] phase_mask(input phase_t p);
    case (p)
      ST_SELECT:    phase_mask = MASK_SELECT;
      ST_COUNTDOWN: phase_mask = MASK_SELECT;
      ST_GAME:      phase_mask = MASK_GAME;
      ST_RESULT:    phase_mask = MASK_RESULT;
      default:      phase_mask = MASK_SELECT;
    endcase
  endfunction

endpackage

// File: rtl/screen_phase_ctrl_frame_timer.sv
// Loadable frame down-counter shared by the countdown and result hold.
// Clear beats load beats decrement; it never wraps below zero.
module screen_phase_ctrl_frame_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/screen_phase_ctrl.sv
// Frame-synchronous screen-phase sequencer: SELECT, COUNTDOWN, GAME, RESULT.
// Events are latched between frame ticks and consumed only at a tick.
module screen_phase_ctrl
  import screen_phase_ctrl_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int RESULT_FRAMES    = 300,
  parameter int CNT_W            = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             confirm,
  input  logic             game_over,
  input  logic             abort,
  output logic [1:0]       enable,
  output logic             game_run,
  output logic             game_start,
  output logic [CNT_W-1:0] frames_left
);

  localparam logic [CNT_W-1:0] CD_LOAD =
    CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] RS_LOAD =
    CNT_W'(RESULT_FRAMES - 1);

  phase_t           phase_q, phase_d;
  logic             cnf_p, ovr_p, abt_p;
  logic             cnf, ovr, abt;
  logic             t_clr, t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_val;
  logic             start_d;
  logic [1:0]       en_q;
  logic             run_q, start_q;

  // A pulse landing on the tick itself is consumed by that tick.
  assign cnf = cnf_p | confirm;
  assign ovr = ovr_p | game_over;
  assign abt = abt_p | abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnf_p <= 1'b0;
      ovr_p <= 1'b0;
      abt_p <= 1'b0;
    end else if (frame_tick) begin
      cnf_p <= 1'b0;
      ovr_p <= 1'b0;
      abt_p <= 1'b0;
    end else begin
      cnf_p <= cnf;
      ovr_p <= ovr;
      abt_p <= abt;
    end
  end

  always_comb begin
    phase_d = phase_q;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_val   = '0;
    start_d = 1'b0;
    if (frame_tick) begin
      if (abt) begin
        phase_d = ST_SELECT;
        t_clr   = 1'b1;
      end else begin
        case (phase_q)
          ST_SELECT: if (cnf) begin
            phase_d = ST_COUNTDOWN;
            t_load  = 1'b1;
            t_val   = CD_LOAD;
          end
          ST_COUNTDOWN: if (t_zero) begin
            phase_d = ST_GAME;
            start_d = 1'b1;
          end else begin
            t_dec = 1'b1;
          end
          ST_GAME: if (ovr) begin
            phase_d = ST_RESULT;
            t_load  = 1'b1;
            t_val   = RS_LOAD;
          end
          ST_RESULT: if (cnf || t_zero) begin
            phase_d = ST_SELECT;
            t_clr   = 1'b1;
          end else begin
            t_dec = 1'b1;
          end
          default: begin
            phase_d = ST_SELECT;
            t_clr   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= ST_SELECT;
      en_q    <= MASK_SELECT;
      run_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      en_q    <= phase_mask(phase_d);
      run_q   <= (phase_d == ST_GAME);
      start_q <= start_d;
    end
  end

  screen_phase_ctrl_frame_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (t_clr),
    .load    (t_load),
    .dec     (t_dec),
    .load_val(t_val),
    .count   (frames_left),
    .zero    (t_zero)
  );

  assign enable     = en_q;
  assign game_run   = run_q;
  assign game_start = start_q;

endmodule

// File: tb/tb_screen_phase_ctrl.sv
// Directed bench for screen_phase_ctrl with a short countdown and hold.
// Expected values are hand-computed for COUNTDOWN_FRAMES=3, RESULT_FRAMES=4.
module tb_screen_phase_ctrl;

  localparam int CF = 3;
  localparam int RF = 4;
  localparam int W  = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_tick, confirm, game_over, abort;
  logic [1:0]   enable;
  logic         game_run, game_start;
  logic [W-1:0] frames_left;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int start_cnt = 0;

  screen_phase_ctrl #(
    .COUNTDOWN_FRAMES(CF),
    .RESULT_FRAMES   (RF),
    .CNT_W           (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .confirm    (confirm),
    .game_over  (game_over),
    .abort      (abort),
    .enable     (enable),
    .game_run   (game_run),
    .game_start (game_start),
    .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (game_start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_confirm();
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
  endtask

  task automatic pulse_over();
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
  endtask

  task automatic chk(input string name,
                     input logic [1:0] en_e,
                     input logic run_e,
                     input logic [W-1:0] fl_e);
    total_cnt++;
    if ({enable, game_run, frames_left} !== {en_e, run_e, fl_e})
      $display("FAIL %s: got en=%b run=%b fl=%0d want en=%b run=%b fl=%0d",
               name, enable, game_run, frames_left, en_e, run_e, fl_e);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    confirm = 1'b0;
    game_over = 1'b0;
    abort = 1'b0;
    idle(3);
    chk("reset_hold", 2'b01, 1'b0, '0);
    total_cnt++;
    if (game_start !== 1'b0)
      $display("FAIL reset_start: got %b want 0", game_start);
    else
      pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(4);
      tick();
      chk("idle_tick", 2'b01, 1'b0, '0);
    end
  endtask

  task automatic test_start_game();
    int s0;
    idle(2);
    pulse_confirm();
    idle(10);
    tick();
    chk("cd_2", 2'b01, 1'b0, 9'd2);
    idle(3);
    chk("cd_stable", 2'b01, 1'b0, 9'd2);
    tick();
    chk("cd_1", 2'b01, 1'b0, 9'd1);
    idle(3);
    tick();
    chk("cd_0", 2'b01, 1'b0, 9'd0);
    idle(3);
    s0 = start_cnt;
    tick();
    chk("game_enter", 2'b00, 1'b1, 9'd0);
    total_cnt++;
    if (game_start !== 1'b1)
      $display("FAIL start_high: got %b want 1", game_start);
    else
      pass_cnt++;
    cyc();
    total_cnt++;
    if (game_start !== 1'b0)
      $display("FAIL start_low: got %b want 0", game_start);
    else
      pass_cnt++;
    total_cnt++;
    if (start_cnt - s0 !== 1)
      $display("FAIL start_width: got %0d want 1", start_cnt - s0);
    else
      pass_cnt++;
  endtask

  task automatic test_round_end();
    idle(2);
    pulse_confirm();
    idle(3);
    tick();
    chk("game_ign_cnf", 2'b00, 1'b1, 9'd0);
    idle(3);
    tick();
    chk("game_no_stale", 2'b00, 1'b1, 9'd0);
    idle(2);
    pulse_over();
    idle(3);
    chk("over_pending", 2'b00, 1'b1, 9'd0);
    tick();
    chk("result_enter", 2'b10, 1'b0, 9'd3);
    for (int k = 2; k >= 0; k--) begin
      idle(3);
      tick();
      chk("result_hold", 2'b10, 1'b0, W'(k));
    end
    idle(3);
    tick();
    chk("result_auto", 2'b01, 1'b0, 9'd0);
  endtask

  task automatic to_game_coincident();
    confirm = 1'b1;
    frame_tick = 1'b1;
    cyc();
    confirm = 1'b0;
    frame_tick = 1'b0;
    chk("coinc_cd", 2'b01, 1'b0, 9'd2);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      tick();
    end
    chk("coinc_game", 2'b00, 1'b1, 9'd0);
  endtask

  task automatic test_coincident();
    idle(3);
    to_game_coincident();
    idle(2);
    game_over = 1'b1;
    frame_tick = 1'b1;
    cyc();
    game_over = 1'b0;
    frame_tick = 1'b0;
    chk("coinc_over", 2'b10, 1'b0, 9'd3);
    idle(2);
    tick();
    chk("res_dec", 2'b10, 1'b0, 9'd2);
    pulse_confirm();
    idle(2);
    tick();
    chk("res_confirm", 2'b01, 1'b0, 9'd0);
  endtask

  task automatic test_priority();
    idle(2);
    pulse_over();
    idle(2);
    tick();
    chk("sel_ign_over", 2'b01, 1'b0, 9'd0);
    to_game_coincident();
    pulse_over();
    tick();
    chk("pri_result", 2'b10, 1'b0, 9'd3);
    abort = 1'b1;
    confirm = 1'b1;
    cyc();
    abort = 1'b0;
    confirm = 1'b0;
    idle(2);
    tick();
    chk("abort_wins", 2'b01, 1'b0, 9'd0);
    idle(2);
    tick();
    chk("no_carry", 2'b01, 1'b0, 9'd0);
    to_game_coincident();
    abort = 1'b1;
    frame_tick = 1'b1;
    cyc();
    abort = 1'b0;
    frame_tick = 1'b0;
    chk("abort_game", 2'b01, 1'b0, 9'd0);
  endtask

  task automatic test_async_reset();
    int s0;
    idle(2);
    pulse_confirm();
    tick();
    idle(2);
    tick();
    chk("pre_rst_cd", 2'b01, 1'b0, 9'd1);
    s0 = start_cnt;
    rst_n = 1'b0;
    #2;
    chk("async_rst", 2'b01, 1'b0, 9'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(2);
      tick();
    end
    chk("post_rst", 2'b01, 1'b0, 9'd0);
    total_cnt++;
    if (start_cnt !== s0)
      $display("FAIL rst_no_start: got %0d want %0d", start_cnt, s0);
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_start_game();
    test_round_end();
    test_coincident();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/screen_phase_ctrl.md
Name: screen_phase_ctrl

Overview:
Top-level screen-phase sequencer for the balance-board game. Drives the 2-bit overlay select consumed by the colour compositor: 01 = select/menu overlay over dimmed field, 00 = live game, 10 = result overlay over dimmed field. Accepts user and game events as single-cycle pulses and latches them. Applies all phase changes only on VGA frame boundaries, so an overlay never switches mid-frame. Also times the pre-game countdown and the result hold.

Parameters:
COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN before GAME (3 s at 60 Hz); legal range 1..2^CNT_W-1
RESULT_FRAMES, 300, frames RESULT is held before auto-return to SELECT; legal range 1..2^CNT_W-1
CNT_W, 9, width of the frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blanking
confirm  in  1  one-cycle pulse, debounced confirm button
game_over  in  1  one-cycle pulse from game logic: round ended
abort  in  1  one-cycle pulse: force return to menu
enable  out  2  overlay select to compositor (01 select, 00 game, 10 result)
game_run  out  1  high while in GAME; gates physics/update logic
game_start  out  1  one-cycle pulse on the clock the FSM enters GAME
frames_left  out  CNT_W  remaining frames in COUNTDOWN/RESULT, 0 otherwise

Behaviour:
- Reset (async, rst_n=0) sets state=SELECT, enable=01, game_run=0, game_start=0, frames_left=0, and all pending flags to 0. Outputs are registered and hold these values until the first clk edge after rst_n rises.
- Pending flags: confirm, game_over and abort each set a sticky flag (cnf_p, ovr_p, abt_p) when they pulse. A pulse coinciding with frame_tick is seen by that tick: the flag and the live input are ORed.
- State and all outputs update only on clk edges where frame_tick=1. Latency: effect is visible 1 clk after the consuming tick. Between ticks the outputs are stable.
- At every tick, all pending flags clear regardless of whether they caused a transition. Stale events never carry over.
- Transitions at a tick, in priority order:
  - abort: from any state go to SELECT, frames_left=0.
  - SELECT: cnf → COUNTDOWN, frames_left=COUNTDOWN_FRAMES-1. Ignore ovr.
  - COUNTDOWN: if frames_left==0 → GAME, else decrement. Ignore cnf and ovr. COUNTDOWN lasts exactly COUNTDOWN_FRAMES ticks.
  - GAME: ovr → RESULT, frames_left=RESULT_FRAMES-1. Ignore cnf.
  - RESULT: cnf → SELECT (skips the hold). Otherwise, if frames_left==0 → SELECT, else decrement. Ignore ovr.
- enable mapping:
  - SELECT → 01
  - COUNTDOWN → 01
  - GAME → 00
  - RESULT → 10
  - 11 is never driven; an illegal state recovers to SELECT on the next tick.
- game_run=1 exactly while state=GAME.
- game_start=1 for one clk, on the same edge that first shows enable=00. It is cleared on the next edge even if that edge is not a tick.
- frames_left=0 in SELECT and GAME.
- The counter never underflows: the zero check precedes the decrement.
- Reset mid-operation: immediate return to the reset values. No pulse is emitted.

Decomposition:
- Add to the shared header: MASK_SELECT=2'b01, MASK_GAME=2'b00, MASK_RESULT=2'b10, and the state encodings. The compositor uses the same MASK_* constants.
- One natural sub-module, frame_timer: a loadable down-counter with load, tick, and a zero flag. Both COUNTDOWN and RESULT reuse it.

Test Plan:
- Reset/idle: hold rst_n=0, then release; run 3 ticks with no events → enable=01, game_run=0, frames_left=0 throughout.
- Start game: COUNTDOWN_FRAMES=3; confirm 10 clk before a tick → enable stays 01 and frames_left goes 2,1,0 over successive ticks. On the 4th tick, enable=00, game_run=1, and game_start is high for exactly 1 clk.
- Coincident event: confirm and frame_tick in the same cycle while in SELECT → COUNTDOWN is entered on that tick.
- Round end: game_over mid-frame in GAME → enable=10 after the next tick, frames_left=RESULT_FRAMES-1. With no confirm, auto-return to 01 after RESULT_FRAMES ticks. A confirm during RESULT returns to 01 at the next tick.
- Ignored and priority events:
  - confirm in GAME → stays in GAME, flag cleared; a game_over on a later frame still goes to RESULT.
  - abort and confirm in the same frame in RESULT → SELECT, not COUNTDOWN.
- Async reset mid-COUNTDOWN: pull rst_n low between ticks → enable=01 and frames_left=0 with no clk edge needed; no game_start follows.
